three_phase_lut_scheduler: RTL

THREE_PHASE_LUT_SCHEDULER -- requirements
Module: three_phase_lut_scheduler

---
 rtl/sine_pkg.sv | 26 ++
 rtl/phase_acc.sv | 53 +++++
 rtl/three_phase_lut_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sine_pkg.sv
// ============================================================================
// sine_pkg : shared LUT depth, phase offsets and scheduler state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package sine_pkg;

    localparam int SINE_LUT_DEPTH = 20000;

    // 0 / 120 / 240 degree starting points, in LUT entries
    localparam int PHASE_A_OFF = 0;
    localparam int PHASE_B_OFF = SINE_LUT_DEPTH / 3;
    localparam int PHASE_C_OFF = (2 * SINE_LUT_DEPTH) / 3;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_A  = 3'd1;
    localparam logic [2:0] ST_RD_B  = 3'd2;
    localparam logic [2:0] ST_RD_C  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

`default_nettype wire

// File: rtl/phase_acc.sv
// ============================================================================
// phase_acc : modulo-LUT_DEPTH phase accumulator with parameterised reset offset
// Revision  : 1.0
// ============================================================================
`default_nettype none

module phase_acc #(
    parameter int ADDR_W    = 15,
    parameter int LUT_DEPTH = 20000,
    parameter int OFFSET    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic [ADDR_W-1:0] step,
    output logic [ADDR_W-1:0] phase
);

    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W+1)'(LUT_DEPTH);
    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(OFFSET);

    logic [ADDR_W-1:0] phase_q;
    logic [ADDR_W-1:0] phase_d;
    logic [ADDR_W:0]   sum;
    logic [ADDR_W:0]   sum_wrapped;

    // Extra carry bit keeps p+step exact before the single-subtract wrap
    always_comb begin
        sum         = {1'b0, phase_q} + {1'b0, step};
        sum_wrapped = sum - DEPTH_W;
        phase_d     = phase_q;
        if (advance) begin
            if (sum >= DEPTH_W) begin
                phase_d = sum_wrapped[ADDR_W-1:0];
            end else begin
                phase_d = sum[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= RESET_VAL;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/three_phase_lut_scheduler.sv
// ============================================================================
// three_phase_lut_scheduler : time-shares one sync sine LUT across three phases
// Revision                  : 1.0
// ============================================================================
`default_nettype none

module three_phase_lut_scheduler
    import sine_pkg::*;
#(
    parameter int LUT_DEPTH = SINE_LUT_DEPTH,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic [ADDR_W-1:0] freq_step,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic              cfg_err
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(LUT_DEPTH);

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] step_q,    step_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] hold_a_q,  hold_a_d;
    logic [DATA_W-1:0] hold_b_q,  hold_b_d;
    logic [DATA_W-1:0] out_a_q,   out_a_d;
    logic [DATA_W-1:0] out_b_q,   out_b_d;
    logic [DATA_W-1:0] out_c_q,   out_c_d;
    logic              valid_q,   valid_d;
    logic              overrun_q, overrun_d;
    logic              cfg_err_q, cfg_err_d;

    logic [ADDR_W-1:0] step_eff;
    logic [ADDR_W-1:0] phase_a;
    logic [ADDR_W-1:0] phase_b;
    logic [ADDR_W-1:0] phase_c;
    logic              is_busy;
    logic              accept;
    logic              step_bad;

    assign is_busy  = (state_q != ST_IDLE);
    assign accept   = !is_busy && sample_tick && enable;
    assign step_bad = ({1'b0, freq_step} >= DEPTH_W);
    // An out-of-range step freezes all three phases
    assign step_eff = ({1'b0, step_q} >= DEPTH_W) ? '0 : step_q;

    phase_acc #(.ADDR_W(ADDR_W), .LUT_DEPTH(LUT_DEPTH), .OFFSET(PHASE_A_OFF)) u_acc_a (
        .clk     (clk),
        .rst     (rst),
        .advance (state_q == ST_RD_A),
        .step    (step_eff),
        .phase   (phase_a)
    );

    phase_acc #(.ADDR_W(ADDR_W), .LUT_DEPTH(LUT_DEPTH), .OFFSET(PHASE_B_OFF)) u_acc_b (
        .clk     (clk),
        .rst     (rst),
        .advance (state_q == ST_RD_B),
        .step    (step_eff),
        .phase   (phase_b)
    );

    phase_acc #(.ADDR_W(ADDR_W), .LUT_DEPTH(LUT_DEPTH), .OFFSET(PHASE_C_OFF)) u_acc_c (
        .clk     (clk),
        .rst     (rst),
        .advance (state_q == ST_RD_C),
        .step    (step_eff),
        .phase   (phase_c)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        addr_d    = addr_q;
        hold_a_d  = hold_a_q;
        hold_b_d  = hold_b_q;
        out_a_d   = out_a_q;
        out_b_d   = out_b_q;
        out_c_d   = out_c_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q | (sample_tick && enable && is_busy);
        cfg_err_d = cfg_err_q;

        // lut_addr is registered one state early so it is stable for the whole read state
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_RD_A;
                    step_d    = freq_step;
                    addr_d    = phase_a;
                    cfg_err_d = cfg_err_q | step_bad;
                end
            end
            ST_RD_A: begin
                state_d = ST_RD_B;
                addr_d  = phase_b;
            end
            ST_RD_B: begin
                state_d  = ST_RD_C;
                addr_d   = phase_c;
                hold_a_d = lut_data;
            end
            ST_RD_C: begin
                state_d  = ST_DRAIN;
                hold_b_d = lut_data;
            end
            ST_DRAIN: begin
                // Phase C data lands straight in out_c, alongside the held A and B words
                state_d = ST_IDLE;
                out_a_d = hold_a_q;
                out_b_d = hold_b_q;
                out_c_d = lut_data;
                valid_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            step_q    <= '0;
            addr_q    <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            out_a_q   <= '0;
            out_b_q   <= '0;
            out_c_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            addr_q    <= addr_d;
            hold_a_q  <= hold_a_d;
            hold_b_q  <= hold_b_d;
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            out_c_q   <= out_c_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign lut_addr  = addr_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_valid = valid_q;
    assign busy      = is_busy;
    assign overrun   = overrun_q;
    assign cfg_err   = cfg_err_q;

endmodule

`default_nettype wire
